signext: RTL and testbench

- Immediate generator for the single-cycle LEGv8 processor.
- Decodes the opcode field of a 32-bit instruction word and extracts the format-specific immediate.
- Sign- or zero-extends that immediate to 64 bits and presents it on a registered output.
- Feeds the ALU B-operand mux and the branch-target adder.

---
 rtl/signext_if.sv | 9 +
 rtl/signext.sv | 48 ++++
 tb/tb_signext.sv | 104 ++++++++++
 3 files changed

// File: rtl/signext_if.sv
// Instruction-in / immediate-out bundle for the LEGv8 immediate generator.
// The master drives the instruction word; the slave returns the extended immediate.
interface signext_if;
  logic [31:0] instr;
  logic [63:0] out;

  modport master (output instr, input out);
  modport slave  (input instr, output out);
endinterface

// File: rtl/signext.sv
// LEGv8 immediate generator: decodes the opcode, extracts the format-specific
// immediate and presents its 64-bit sign/zero extension one cycle later.
module signext (
  input  logic     clk,
  input  logic     reset,
  signext_if.slave bus
);

  localparam logic [10:0] OpLdur  = 11'b11111000010;
  localparam logic [10:0] OpStur  = 11'b11111000000;
  localparam logic [7:0]  OpCbz   = 8'b10110100;
  localparam logic [7:0]  OpCbnz  = 8'b10110101;
  localparam logic [5:0]  OpB     = 6'b000101;
  localparam logic [5:0]  OpBl    = 6'b100101;
  localparam logic [9:0]  OpAddi  = 10'b1001000100;
  localparam logic [9:0]  OpAddis = 10'b1011000100;
  localparam logic [9:0]  OpSubi  = 10'b1101000100;
  localparam logic [9:0]  OpSubis = 10'b1111000100;

  logic [63:0] out_d;
  logic [63:0] out_q;

  // Branch offsets leave unshifted; the word-to-byte scaling happens downstream.
  always_comb begin
    out_d = '0;
    if (bus.instr[31:21] == OpLdur || bus.instr[31:21] == OpStur) begin
      out_d = {{55{bus.instr[20]}}, bus.instr[20:12]};
    end else if (bus.instr[31:24] == OpCbz || bus.instr[31:24] == OpCbnz) begin
      out_d = {{45{bus.instr[23]}}, bus.instr[23:5]};
    end else if (bus.instr[31:26] == OpB || bus.instr[31:26] == OpBl) begin
      out_d = {{38{bus.instr[25]}}, bus.instr[25:0]};
    end else if (bus.instr[31:22] == OpAddi  || bus.instr[31:22] == OpAddis ||
                 bus.instr[31:22] == OpSubi  || bus.instr[31:22] == OpSubis) begin
      out_d = {52'b0, bus.instr[21:10]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_signext.sv
// Directed-vector bench for the LEGv8 immediate generator with hand-computed
// expected immediates for every instruction format.
module tb_signext;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  signext_if bus ();

  signext dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive on the falling edge, then check one step after the next rising edge.
  task automatic applyStimulus(input string tag, input logic [31:0] instrVal,
                               input logic [63:0] expected);
    @(negedge clk);
    bus.instr = instrVal;
    @(posedge clk);
    #1;
    checkOutput(tag, bus.out, expected);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset       = 1'b0;
    bus.instr   = {11'b11111000000, 9'h001, 2'b00, 5'd0, 5'd0};

    #1;
    checkOutput("reset_initial", bus.out, 64'h0);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput("reset_held", bus.out, 64'h0);
    end

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", bus.out, 64'h1);

    applyStimulus("stur_pos",   {11'b11111000000, 9'h0FF, 2'b11, 5'd2, 5'd1}, 64'h0000_0000_0000_00FF);
    applyStimulus("stur_neg",   {11'b11111000000, 9'h1FF, 2'b11, 5'd2, 5'd1}, 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("ldur_min",   {11'b11111000010, 9'h100, 2'b00, 5'd0, 5'd0}, 64'hFFFF_FFFF_FFFF_FF00);
    applyStimulus("cbz_pos",    {8'b10110100, 19'h3FFFF, 5'd1},                64'h0000_0000_0003_FFFF);
    applyStimulus("cbz_neg",    {8'b10110100, 19'h7FFFF, 5'd1},                64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus("cbnz_min",   {8'b10110101, 19'h40000, 5'd0},                64'hFFFF_FFFF_FFFC_0000);
    applyStimulus("cbz_zero",   {8'b10110100, 19'h00000, 5'd31},               64'h0);
    applyStimulus("b_min",      {6'b000101, 26'h2000000},                      64'hFFFF_FFFF_FE00_0000);
    applyStimulus("bl_max",     {6'b100101, 26'h1FFFFFF},                      64'h0000_0000_01FF_FFFF);
    applyStimulus("addi_max",   {10'b1001000100, 12'hFFF, 10'h3FF},            64'h0000_0000_0000_0FFF);
    applyStimulus("subis_msb",  {10'b1111000100, 12'h800, 10'h000},            64'h0000_0000_0000_0800);
    applyStimulus("rformat",    {11'b10001011000, 21'h1FFFFF},                 64'h0);
    applyStimulus("near_stur",  {11'b11111000001, 9'h0FF, 12'hFFF},            64'h0);

    // Back-to-back: value must change on each edge and not before it.
    applyStimulus("b2b_first",  {11'b11111000000, 9'h1FF, 2'b11, 5'd2, 5'd1}, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    bus.instr = {8'b10110100, 19'h3FFFF, 5'd1};
    #1;
    checkOutput("b2b_latency", bus.out, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    checkOutput("b2b_second", bus.out, 64'h0000_0000_0003_FFFF);

    // Asynchronous reset mid-cycle, with a nonzero capture pending.
    @(negedge clk);
    bus.instr = {6'b000101, 26'h0000123};
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", bus.out, 64'h0);
    @(posedge clk);
    #1;
    checkOutput("async_reset_held", bus.out, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset", bus.out, 64'h0000_0000_0000_0123);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
